// File: rtl/mario_sound_mixer_pkg.sv
// Shared definitions for the Mario sound mixer: widths, gain normalisation and FSM states.
package mario_sound_mixer_pkg;

    localparam int unsigned SAMPLE_W       = 16;
    localparam int unsigned GAIN_W         = 4;
    localparam int unsigned PROD_W         = SAMPLE_W + GAIN_W + 1;
    localparam int unsigned ACC_W          = 20;
    localparam int unsigned GAIN_SHIFT_DEF = 3;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 20'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -20'sd32768;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC0,
        ST_MAC1,
        ST_MAC2,
        ST_MAC3,
        ST_SAT,
        ST_FILT
    } state_t;

endpackage

// File: rtl/mario_sound_mixer_mac.sv
// Serial multiply-shift-accumulate datapath: one channel per enabled clock.
module mario_mix_mac
    import mario_sound_mixer_pkg::*;
#(
    parameter int unsigned GAIN_SHIFT = GAIN_SHIFT_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clear,
    input  logic                       i_en,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    input  logic        [GAIN_W-1:0]   i_gain,
    output logic signed [ACC_W-1:0]    o_acc
);

    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_scaled;
    logic signed [ACC_W-1:0]  w_term;
    logic signed [ACC_W-1:0]  r_acc;

    // Gain is zero-extended so 15 stays positive (1.875x at GAIN_SHIFT=3).
    assign w_prod   = i_sample * $signed({1'b0, i_gain});
    assign w_scaled = w_prod >>> GAIN_SHIFT;
    assign w_term   = ACC_W'(w_scaled);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_term;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mario_sound_mixer.sv
// Mixes skid, Mario-run, Luigi-run and sound-CPU DAC samples into one saturated,
// low-pass filtered signed 16-bit mono stream, one update per sample strobe.
module mario_sound_mixer
    import mario_sound_mixer_pkg::*;
#(
    parameter int unsigned FILT_SHIFT = 2,
    parameter int unsigned GAIN_SHIFT = GAIN_SHIFT_DEF
) (
    input  logic                       I_CLK_24M,
    input  logic                       I_RESET,
    input  logic                       I_SAMPLE_STB,
    input  logic signed [SAMPLE_W-1:0] I_WAV_DS0,
    input  logic signed [SAMPLE_W-1:0] I_WAV_DS1,
    input  logic signed [SAMPLE_W-1:0] I_WAV_DS2,
    input  logic signed [SAMPLE_W-1:0] I_DIG_SND,
    input  logic        [GAIN_W-1:0]   I_ANLG_GAIN,
    input  logic        [GAIN_W-1:0]   I_DIG_GAIN,
    input  logic                       I_MUTE,
    output logic signed [SAMPLE_W-1:0] O_SND,
    output logic                       O_SND_VALID,
    output logic                       O_CLIP,
    output logic                       O_OVERRUN
);

    state_t r_state;
    state_t w_next_state;

    logic signed [SAMPLE_W-1:0] r_ds0, r_ds1, r_ds2, r_dig;
    logic        [GAIN_W-1:0]   r_anlg_gain, r_dig_gain;
    logic                       r_mute;

    logic signed [SAMPLE_W-1:0] r_sat;
    logic                       r_clip_pend;
    logic signed [SAMPLE_W-1:0] r_y;
    logic                       r_clip;
    logic                       r_valid;
    logic                       r_overrun;

    logic                       w_start;
    logic                       w_mac_en;
    logic signed [SAMPLE_W-1:0] w_mac_sample;
    logic        [GAIN_W-1:0]   w_mac_gain;
    logic signed [ACC_W-1:0]    w_acc;
    logic signed [SAMPLE_W-1:0] w_sat;
    logic                       w_clip;
    logic signed [SAMPLE_W:0]   w_diff;
    logic signed [SAMPLE_W:0]   w_step;
    logic signed [SAMPLE_W:0]   w_y_new;

    assign w_start = I_SAMPLE_STB && (r_state == ST_IDLE);

    always_ff @(posedge I_CLK_24M or posedge I_RESET) begin
        if (I_RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mac_en     = 1'b0;
        w_mac_sample = '0;
        w_mac_gain   = '0;
        case (r_state)
            ST_IDLE: if (I_SAMPLE_STB) w_next_state = ST_MAC0;
            ST_MAC0: begin
                w_next_state = ST_MAC1;
                w_mac_en     = 1'b1;
                w_mac_sample = r_ds0;
                w_mac_gain   = r_anlg_gain;
            end
            ST_MAC1: begin
                w_next_state = ST_MAC2;
                w_mac_en     = 1'b1;
                w_mac_sample = r_ds1;
                w_mac_gain   = r_anlg_gain;
            end
            ST_MAC2: begin
                w_next_state = ST_MAC3;
                w_mac_en     = 1'b1;
                w_mac_sample = r_ds2;
                w_mac_gain   = r_anlg_gain;
            end
            ST_MAC3: begin
                w_next_state = ST_SAT;
                w_mac_en     = 1'b1;
                w_mac_sample = r_dig;
                w_mac_gain   = r_dig_gain;
            end
            ST_SAT:  w_next_state = ST_FILT;
            ST_FILT: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    mario_mix_mac #(
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_mac (
        .i_clk    (I_CLK_24M),
        .i_rst    (I_RESET),
        .i_clear  (w_start),
        .i_en     (w_mac_en),
        .i_sample (w_mac_sample),
        .i_gain   (w_mac_gain),
        .o_acc    (w_acc)
    );

    always_comb begin
        w_sat  = SAMPLE_W'(w_acc);
        w_clip = 1'b0;
        if (w_acc > SAT_MAX) begin
            w_sat  = SAMPLE_W'(SAT_MAX);
            w_clip = 1'b1;
        end else if (w_acc < SAT_MIN) begin
            w_sat  = SAMPLE_W'(SAT_MIN);
            w_clip = 1'b1;
        end
    end

    // 17-bit difference keeps the full swing; the result is a convex step so it never leaves 16 bits.
    assign w_diff  = {r_sat[SAMPLE_W-1], r_sat} - {r_y[SAMPLE_W-1], r_y};
    assign w_step  = w_diff >>> FILT_SHIFT;
    assign w_y_new = {r_y[SAMPLE_W-1], r_y} + w_step;

    always_ff @(posedge I_CLK_24M or posedge I_RESET) begin
        if (I_RESET) begin
            r_ds0       <= '0;
            r_ds1       <= '0;
            r_ds2       <= '0;
            r_dig       <= '0;
            r_anlg_gain <= '0;
            r_dig_gain  <= '0;
            r_mute      <= 1'b0;
            r_sat       <= '0;
            r_clip_pend <= 1'b0;
            r_y         <= '0;
            r_clip      <= 1'b0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_valid   <= (r_state == ST_FILT);
            r_overrun <= I_SAMPLE_STB && (r_state != ST_IDLE);
            if (w_start) begin
                r_ds0       <= I_WAV_DS0;
                r_ds1       <= I_WAV_DS1;
                r_ds2       <= I_WAV_DS2;
                r_dig       <= I_DIG_SND;
                r_anlg_gain <= I_ANLG_GAIN;
                r_dig_gain  <= I_DIG_GAIN;
                r_mute      <= I_MUTE;
            end
            if (r_state == ST_SAT) begin
                r_sat       <= r_mute ? '0 : w_sat;
                r_clip_pend <= !r_mute && w_clip;
            end
            if (r_state == ST_FILT) begin
                r_y    <= SAMPLE_W'(w_y_new);
                r_clip <= r_clip_pend;
            end
        end
    end

    assign O_SND       = r_y;
    assign O_SND_VALID = r_valid;
    assign O_CLIP      = r_clip;
    assign O_OVERRUN   = r_overrun;

endmodule

// File: tb/tb_mario_sound_mixer.sv
// Directed bench: a bypass-filter instance and a FILT_SHIFT=2 instance share all stimulus.
module tb_mario_sound_mixer;

    logic clk = 1'b0;
    logic rst;
    logic stb;
    logic signed [15:0] ds0, ds1, ds2, dig;
    logic [3:0] ag, dg;
    logic mute;

    logic signed [15:0] snd0, snd2;
    logic val0, val2, clip0, clip2, ovr0, ovr2;

    int checks   = 0;
    int failures = 0;
    int nvalid;

    always #5 clk = ~clk;

    mario_sound_mixer #(.FILT_SHIFT(0), .GAIN_SHIFT(3)) dut0 (
        .I_CLK_24M(clk), .I_RESET(rst), .I_SAMPLE_STB(stb),
        .I_WAV_DS0(ds0), .I_WAV_DS1(ds1), .I_WAV_DS2(ds2), .I_DIG_SND(dig),
        .I_ANLG_GAIN(ag), .I_DIG_GAIN(dg), .I_MUTE(mute),
        .O_SND(snd0), .O_SND_VALID(val0), .O_CLIP(clip0), .O_OVERRUN(ovr0)
    );

    mario_sound_mixer #(.FILT_SHIFT(2), .GAIN_SHIFT(3)) dut2 (
        .I_CLK_24M(clk), .I_RESET(rst), .I_SAMPLE_STB(stb),
        .I_WAV_DS0(ds0), .I_WAV_DS1(ds1), .I_WAV_DS2(ds2), .I_DIG_SND(dig),
        .I_ANLG_GAIN(ag), .I_DIG_GAIN(dg), .I_MUTE(mute),
        .O_SND(snd2), .O_SND_VALID(val2), .O_CLIP(clip2), .O_OVERRUN(ovr2)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Returns at the negedge just after the accepting edge T.
    task automatic pulse_strobe();
        @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
    endtask

    // Returns at the negedge after T+6, while O_SND_VALID is high.
    task automatic run_mix();
        pulse_strobe();
        wait_neg(6);
    endtask

    task automatic set_in(input logic signed [15:0] a, input logic signed [15:0] b,
                          input logic signed [15:0] c, input logic signed [15:0] d,
                          input logic [3:0] ga, input logic [3:0] gd);
        ds0 = a; ds1 = b; ds2 = c; dig = d; ag = ga; dg = gd;
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; mute = 1'b0;
        set_in(16'sd0, 16'sd0, 16'sd0, 16'sd0, 4'd0, 4'd0);
        wait_neg(3);
        check("reset_snd", snd0, 0);
        check("reset_valid", val0, 0);
        check("reset_clip", clip0, 0);
        check("reset_overrun", ovr0, 0);
        rst = 1'b0;
        wait_neg(2);

        // Unity gain, exact latency
        set_in(16'sd1000, 16'sd0, 16'sd0, 16'sd0, 4'd8, 4'd8);
        pulse_strobe();
        wait_neg(5);
        check("unity_before_T6_snd", snd0, 0);
        check("unity_before_T6_valid", val0, 0);
        wait_neg(1);
        check("unity_snd", snd0, 1000);
        check("unity_valid", val0, 1);
        check("unity_clip", clip0, 0);
        wait_neg(1);
        check("unity_valid_one_cycle", val0, 0);

        // Four channels, mixed gains, negative rounding: 1500+3000-752+200
        set_in(16'sd1000, 16'sd2000, -16'sd501, 16'sd400, 4'd12, 4'd4);
        run_mix();
        check("mix_snd", snd0, 3948);
        check("mix_clip", clip0, 0);

        // Gain 0 removes a channel
        set_in(16'sd1000, 16'sd0, 16'sd0, -16'sd3000, 4'd8, 4'd0);
        run_mix();
        check("gain0_snd", snd0, 1000);

        set_in(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 4'd15, 4'd15);
        run_mix();
        check("sat_pos_snd", snd0, 32767);
        check("sat_pos_clip", clip0, 1);
        wait_neg(3);
        check("clip_held", clip0, 1);

        set_in(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 4'd15, 4'd15);
        run_mix();
        check("sat_neg_snd", snd0, -32768);
        check("sat_neg_clip", clip0, 1);

        // Overrun: second strobe at T+3 with different data
        set_in(16'sd1000, 16'sd0, 16'sd0, 16'sd0, 4'd8, 4'd8);
        pulse_strobe();
        nvalid = 0;
        wait_neg(1);
        nvalid += int'(val0);
        wait_neg(1);
        nvalid += int'(val0);
        stb = 1'b1;
        ds0 = 16'sd5000;
        wait_neg(1);
        stb = 1'b0;
        nvalid += int'(val0);
        check("overrun_pulse", ovr0, 1);
        wait_neg(1);
        nvalid += int'(val0);
        check("overrun_one_cycle", ovr0, 0);
        for (int i = 0; i < 8; i++) begin
            wait_neg(1);
            nvalid += int'(val0);
        end
        check("overrun_valid_count", nvalid, 1);
        check("overrun_snd", snd0, 1000);
        check("overrun_clip", clip0, 0);

        // Reset mid-sequence
        set_in(16'sd2000, 16'sd0, 16'sd0, 16'sd0, 4'd8, 4'd8);
        pulse_strobe();
        wait_neg(3);
        rst = 1'b1;
        #1;
        check("midrst_snd", snd0, 0);
        check("midrst_snd_filt", snd2, 0);
        check("midrst_valid", val0, 0);
        check("midrst_overrun", ovr0, 0);
        wait_neg(2);
        rst = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            wait_neg(1);
            nvalid += int'(val0) + int'(val2);
        end
        check("midrst_no_valid", nvalid, 0);

        // Filter step (first strobe after reset also checks normal mixing)
        set_in(16'sd0, 16'sd0, 16'sd0, 16'sd4096, 4'd8, 4'd8);
        run_mix();
        check("post_reset_snd", snd0, 4096);
        check("filt_step1", snd2, 1024);
        check("filt_valid", val2, 1);
        run_mix();
        check("filt_step2", snd2, 1792);
        run_mix();
        check("filt_step3", snd2, 2368);

        // Approach 4096 from above so the floor shift settles exactly
        set_in(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 4'd15, 4'd15);
        for (int i = 0; i < 25; i++) run_mix();
        set_in(16'sd0, 16'sd0, 16'sd0, 16'sd4096, 4'd8, 4'd8);
        for (int i = 0; i < 50; i++) run_mix();
        check("settled_4096", snd2, 4096);

        // Mute with saturating inputs: decay and clip forced low
        mute = 1'b1;
        set_in(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 4'd15, 4'd15);
        run_mix();
        check("mute_step1", snd2, 3072);
        check("mute_clip", clip2, 0);
        check("mute_bypass_snd", snd0, 0);
        run_mix();
        check("mute_step2", snd2, 2304);
        run_mix();
        check("mute_step3", snd2, 1728);
        check("mute_clip_end", clip2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
